// File: rtl/pmem_arbiter_if.sv
// Shared physical-memory bus between I-cache, D-cache and main memory.
// The master side drives requests and memory replies; the slave side is the arbiter.
interface pmem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  logic                  icache_read;
  logic [ADDR_WIDTH-1:0] icache_address;
  logic [LINE_WIDTH-1:0] icache_rdata;
  logic                  icache_resp;

  logic                  dcache_read;
  logic                  dcache_write;
  logic [ADDR_WIDTH-1:0] dcache_address;
  logic [LINE_WIDTH-1:0] dcache_wdata;
  logic [LINE_WIDTH-1:0] dcache_rdata;
  logic                  dcache_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport master (
    output icache_read, icache_address,
    output dcache_read, dcache_write,
    output dcache_address, dcache_wdata,
    output pmem_rdata, pmem_resp,
    input  icache_rdata, icache_resp,
    input  dcache_rdata, dcache_resp,
    input  pmem_read, pmem_write,
    input  pmem_address, pmem_wdata
  );

  modport slave (
    input  icache_read, icache_address,
    input  dcache_read, dcache_write,
    input  dcache_address, dcache_wdata,
    input  pmem_rdata, pmem_resp,
    output icache_rdata, icache_resp,
    output dcache_rdata, dcache_resp,
    output pmem_read, pmem_write,
    output pmem_address, pmem_wdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// I/D-cache arbiter for one physical-memory port, one grant per line transaction.
// Round-robin by default; define ARB_DCACHE_PRIORITY_EN for fixed D-cache priority.
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input logic clk,
  input logic reset,
  pmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } state_t;

  state_t state_q;
  state_t state_d;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;

  logic                  rd_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;

`ifndef ARB_DCACHE_PRIORITY_EN
  // 0 = I-cache won last, 1 = D-cache won last
  logic last_grant_q;
`endif

  assign i_req = bus.icache_read;
  assign d_req = bus.dcache_read | bus.dcache_write;

  // Pick a winner in IDLE and hold the grant until memory replies
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
`ifdef ARB_DCACHE_PRIORITY_EN
          grant_d = 1'b1;
`else
          grant_d = ~last_grant_q;
          grant_i = last_grant_q;
`endif
        end else begin
          grant_i = i_req;
          grant_d = d_req;
        end
        if (grant_i) begin
          state_d = I_BUSY;
        end else if (grant_d) begin
          state_d = D_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (bus.pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifndef ARB_DCACHE_PRIORITY_EN
  // Remember the last winner so contention alternates
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b0;
    end else if (grant_i) begin
      last_grant_q <= 1'b0;
    end else if (grant_d) begin
      last_grant_q <= 1'b1;
    end
  end
`endif

  // Capture the winner's op, address and data at the grant edge
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_i) begin
      rd_q   <= 1'b1;
      wr_q   <= 1'b0;
      addr_q <= bus.icache_address;
    end else if (grant_d) begin
      rd_q    <= bus.dcache_read & ~bus.dcache_write;
      wr_q    <= bus.dcache_write;
      addr_q  <= bus.dcache_address;
      wdata_q <= bus.dcache_wdata;
    end else if (state_q != IDLE && bus.pmem_resp) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end
  end

  assign bus.pmem_read    = rd_q;
  assign bus.pmem_write   = wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  assign bus.icache_resp  = (state_q == I_BUSY) & bus.pmem_resp;
  assign bus.dcache_resp  = (state_q == D_BUSY) & bus.pmem_resp;
  assign bus.icache_rdata = bus.pmem_rdata;
  assign bus.dcache_rdata = bus.pmem_rdata;

endmodule
